// File: rtl/mips_branch_pkg.sv
// Shared encodings and types for the MIPS branch/jump resolution unit.
// Opcode, function and REGIMM selector values follow the MIPS32 encoding.
package mips_branch_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] OP_BEQL    = 6'h14;
  localparam logic [5:0] OP_BNEL    = 6'h15;
  localparam logic [5:0] OP_BLEZL   = 6'h16;
  localparam logic [5:0] OP_BGTZL   = 6'h17;

  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_JALR    = 6'h09;

  localparam logic [4:0] RT_BLTZ    = 5'h00;
  localparam logic [4:0] RT_BGEZ    = 5'h01;
  localparam logic [4:0] RT_BLTZL   = 5'h02;
  localparam logic [4:0] RT_BGEZL   = 5'h03;
  localparam logic [4:0] RT_BLTZAL  = 5'h10;
  localparam logic [4:0] RT_BGEZAL  = 5'h11;
  localparam logic [4:0] RT_BLTZALL = 5'h12;
  localparam logic [4:0] RT_BGEZALL = 5'h13;

  localparam logic [4:0] LINK_RA    = 5'd31;

  typedef enum logic [3:0] {NONE, JUMP, JREG, EQ, NE, LEZ, GTZ, LTZ, GEZ} branch_kind_t;

  typedef struct packed {
    branch_kind_t kind;
    logic         taken;
    logic         is_link;
    logic         is_likely;
  } branch_dec_t;

  typedef enum logic [1:0] {IDLE, ARMED, SLOT} bdu_state_t;

  // Jumps are unconditional; every branch reduces to equality, sign or zero of rs.
  function automatic logic kind_taken(branch_kind_t kind, logic eq, logic neg, logic zero);
    case (kind)
      JUMP, JREG: kind_taken = 1'b1;
      EQ:         kind_taken = eq;
      NE:         kind_taken = !eq;
      LEZ:        kind_taken = neg | zero;
      GTZ:        kind_taken = !(neg | zero);
      LTZ:        kind_taken = neg;
      GEZ:        kind_taken = !neg;
      default:    kind_taken = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational decode of control-transfer instructions and evaluation of
// their branch condition from the register operands.
module branch_cond_eval
  import mips_branch_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter bit LIKELY_EN = 1'b1
) (
  input  logic [5:0]        opcode,
  input  logic [5:0]        fn,
  input  logic [4:0]        rt_field,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  output branch_dec_t       dec
);

  logic eq, neg, zero;

  assign eq   = (rs_data == rt_data);
  assign neg  = rs_data[DATA_W-1];
  assign zero = (rs_data == '0);

  always_comb begin
    dec.kind      = NONE;
    dec.is_link   = 1'b0;
    dec.is_likely = 1'b0;
    case (opcode)
      OP_SPECIAL: begin
        if (fn == FN_JR) begin
          dec.kind = JREG;
        end else if (fn == FN_JALR) begin
          dec.kind    = JREG;
          dec.is_link = 1'b1;
        end
      end
      OP_J:    dec.kind = JUMP;
      OP_JAL:  begin dec.kind = JUMP; dec.is_link = 1'b1; end
      OP_BEQ:  dec.kind = EQ;
      OP_BNE:  dec.kind = NE;
      OP_BLEZ: dec.kind = LEZ;
      OP_BGTZ: dec.kind = GTZ;
      // Likely forms vanish entirely when disabled, so they decode as ordinary ALU ops.
      OP_BEQL:  if (LIKELY_EN) begin dec.kind = EQ;  dec.is_likely = 1'b1; end
      OP_BNEL:  if (LIKELY_EN) begin dec.kind = NE;  dec.is_likely = 1'b1; end
      OP_BLEZL: if (LIKELY_EN) begin dec.kind = LEZ; dec.is_likely = 1'b1; end
      OP_BGTZL: if (LIKELY_EN) begin dec.kind = GTZ; dec.is_likely = 1'b1; end
      OP_REGIMM: begin
        case (rt_field)
          RT_BLTZ:   dec.kind = LTZ;
          RT_BGEZ:   dec.kind = GEZ;
          RT_BLTZAL: begin dec.kind = LTZ; dec.is_link = 1'b1; end
          RT_BGEZAL: begin dec.kind = GEZ; dec.is_link = 1'b1; end
          RT_BLTZL:  if (LIKELY_EN) begin dec.kind = LTZ; dec.is_likely = 1'b1; end
          RT_BGEZL:  if (LIKELY_EN) begin dec.kind = GEZ; dec.is_likely = 1'b1; end
          RT_BLTZALL: if (LIKELY_EN) begin
            dec.kind = LTZ; dec.is_link = 1'b1; dec.is_likely = 1'b1;
          end
          RT_BGEZALL: if (LIKELY_EN) begin
            dec.kind = GEZ; dec.is_link = 1'b1; dec.is_likely = 1'b1;
          end
          default: dec.kind = NONE;
        endcase
      end
      default: dec.kind = NONE;
    endcase
    dec.taken = kind_taken(dec.kind, eq, neg, zero);
  end

endmodule

// File: rtl/branch_delay_unit.sv
// Sequential branch/jump resolution: latches the target at resolve time and
// redirects the PC on the second PC advance, after the delay slot.
module branch_delay_unit
  import mips_branch_pkg::*;
#(
  parameter int                 DATA_W        = 32,
  parameter int                 STATE_W       = 4,
  parameter logic [STATE_W-1:0] RESOLVE_STATE = 4'b0010,
  parameter bit                 LIKELY_EN     = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [STATE_W-1:0] state,
  input  logic [5:0]         opcode,
  input  logic [5:0]         fn,
  input  logic [4:0]         rt_field,
  input  logic [4:0]         rd_field,
  input  logic [15:0]        imm,
  input  logic [25:0]        instr_index,
  input  logic [DATA_W-1:0]  pc,
  input  logic [DATA_W-1:0]  rs_data,
  input  logic [DATA_W-1:0]  rt_data,
  input  logic               pc_advance,
  output logic               redirect,
  output logic [DATA_W-1:0]  target,
  output logic               annul,
  output logic               link_en,
  output logic [4:0]         link_reg,
  output logic [DATA_W-1:0]  link_value,
  output logic               addr_fault,
  output logic               slot_violation,
  output logic               busy
);

  bdu_state_t        fsm_q, fsm_d;
  logic [DATA_W-1:0] target_q, target_d;
  branch_dec_t       dec;
  logic [DATA_W-1:0] pc_plus4, br_offset, xfer_tgt;
  logic              in_resolve, is_xfer, misaligned, idle_resolve, take;

  branch_cond_eval #(
    .DATA_W    (DATA_W),
    .LIKELY_EN (LIKELY_EN)
  ) u_cond (
    .opcode   (opcode),
    .fn       (fn),
    .rt_field (rt_field),
    .rs_data  (rs_data),
    .rt_data  (rt_data),
    .dec      (dec)
  );

  assign pc_plus4  = pc + DATA_W'(4);
  assign br_offset = {{(DATA_W-18){imm[15]}}, imm, 2'b00};

  always_comb begin
    xfer_tgt = pc_plus4 + br_offset;
    if (dec.kind == JUMP) xfer_tgt = {pc_plus4[DATA_W-1:28], instr_index, 2'b00};
    else if (dec.kind == JREG) xfer_tgt = rs_data;
  end

  // Decodes only act from IDLE; in SLOT they are flagged, in ARMED ignored.
  assign in_resolve   = (state == RESOLVE_STATE);
  assign is_xfer      = (dec.kind != NONE);
  assign misaligned   = (dec.kind == JREG) && (rs_data[1:0] != 2'b00);
  assign idle_resolve = in_resolve && (fsm_q == IDLE) && is_xfer;
  assign take         = idle_resolve && dec.taken && !misaligned;

  always_comb begin
    fsm_d    = fsm_q;
    target_d = target_q;
    case (fsm_q)
      IDLE: begin
        if (take) begin
          target_d = xfer_tgt;
          fsm_d    = pc_advance ? SLOT : ARMED;
        end
      end
      ARMED:   if (pc_advance) fsm_d = SLOT;
      SLOT:    if (pc_advance) fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q    <= IDLE;
      target_q <= '0;
    end else begin
      fsm_q    <= fsm_d;
      target_q <= target_d;
    end
  end

  assign target         = target_q;
  assign redirect       = !reset && (fsm_q == SLOT) && pc_advance;
  assign busy           = !reset && (fsm_q != IDLE);
  assign link_en        = !reset && idle_resolve && dec.is_link;
  assign annul          = !reset && idle_resolve && dec.is_likely && !dec.taken;
  assign addr_fault     = !reset && idle_resolve && misaligned;
  assign slot_violation = !reset && in_resolve && (fsm_q == SLOT) && is_xfer;
  assign link_reg       = reset ? 5'd0 : ((dec.kind == JREG) ? rd_field : LINK_RA);
  assign link_value     = reset ? '0 : (pc + DATA_W'(8));

endmodule

// File: tb/tb_branch_delay_unit.sv
// Scoreboard bench for branch_delay_unit: a likely-enabled and a likely-disabled
// instance share stimulus; expected outputs are queued per cycle and popped on sampling.
module tb_branch_delay_unit;

  localparam logic [3:0] RS = 4'b0010;
  localparam logic [3:0] OT = 4'b0001;
  localparam logic [31:0] NOP = 32'h0000_0000;

  typedef struct packed {
    logic        rst;
    logic [3:0]  st;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        adv;
  } stim_t;

  typedef struct packed {
    logic        redirect;
    logic        annul;
    logic        link_en;
    logic        addr_fault;
    logic        slot_violation;
    logic        busy;
    logic [4:0]  link_reg;
    logic [31:0] link_value;
    logic [31:0] target;
    logic [5:0]  nl;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  state = 4'h0;
  logic [5:0]  opcode = '0, fn = '0;
  logic [4:0]  rt_field = '0, rd_field = '0;
  logic [15:0] imm = '0;
  logic [25:0] instr_index = '0;
  logic [31:0] pc = '0, rs_data = '0, rt_data = '0;
  logic        pc_advance = 1'b0;

  logic        redirect, annul, link_en, addr_fault, slot_violation, busy;
  logic [4:0]  link_reg;
  logic [31:0] target, link_value;
  logic        nl_redirect, nl_annul, nl_link_en, nl_addr_fault, nl_slot_violation, nl_busy;
  logic [4:0]  nl_link_reg;
  logic [31:0] nl_target, nl_link_value;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  branch_delay_unit #(.DATA_W(32), .STATE_W(4), .RESOLVE_STATE(4'b0010), .LIKELY_EN(1'b1)) u_dut (
    .clk(clk), .reset(reset), .state(state), .opcode(opcode), .fn(fn),
    .rt_field(rt_field), .rd_field(rd_field), .imm(imm), .instr_index(instr_index),
    .pc(pc), .rs_data(rs_data), .rt_data(rt_data), .pc_advance(pc_advance),
    .redirect(redirect), .target(target), .annul(annul), .link_en(link_en),
    .link_reg(link_reg), .link_value(link_value), .addr_fault(addr_fault),
    .slot_violation(slot_violation), .busy(busy)
  );

  branch_delay_unit #(.DATA_W(32), .STATE_W(4), .RESOLVE_STATE(4'b0010), .LIKELY_EN(1'b0)) u_dut_nl (
    .clk(clk), .reset(reset), .state(state), .opcode(opcode), .fn(fn),
    .rt_field(rt_field), .rd_field(rd_field), .imm(imm), .instr_index(instr_index),
    .pc(pc), .rs_data(rs_data), .rt_data(rt_data), .pc_advance(pc_advance),
    .redirect(nl_redirect), .target(nl_target), .annul(nl_annul), .link_en(nl_link_en),
    .link_reg(nl_link_reg), .link_value(nl_link_value), .addr_fault(nl_addr_fault),
    .slot_violation(nl_slot_violation), .busy(nl_busy)
  );

  function automatic stim_t mk_s(logic rst, logic [3:0] st, logic [31:0] instr,
                                 logic [31:0] p, logic [31:0] rs, logic [31:0] rt, logic adv);
    stim_t x;
    x.rst = rst; x.st = st; x.instr = instr; x.pc = p; x.rs = rs; x.rt = rt; x.adv = adv;
    return x;
  endfunction

  // The likely-disabled instance is expected to match unless a test overrides nl.
  function automatic exp_t mk_e(logic rd, logic an, logic le, logic af, logic sv, logic bz,
                                logic [4:0] lr, logic [31:0] lv, logic [31:0] tg);
    exp_t e;
    e.redirect = rd; e.annul = an; e.link_en = le; e.addr_fault = af;
    e.slot_violation = sv; e.busy = bz; e.link_reg = lr; e.link_value = lv; e.target = tg;
    e.nl = {rd, an, le, af, sv, bz};
    return e;
  endfunction

  function automatic exp_t observe();
    exp_t o;
    o.redirect       = redirect;
    o.annul          = annul;
    o.link_en        = link_en;
    o.addr_fault     = addr_fault;
    o.slot_violation = slot_violation;
    o.busy           = busy;
    o.link_reg       = link_en ? link_reg : 5'd0;
    o.link_value     = link_en ? link_value : 32'd0;
    o.target         = target;
    o.nl = {nl_redirect, nl_annul, nl_link_en, nl_addr_fault, nl_slot_violation, nl_busy};
    return o;
  endfunction

  task automatic drive(input stim_t x);
    @(negedge clk);
    reset       = x.rst;
    state       = x.st;
    opcode      = x.instr[31:26];
    fn          = x.instr[5:0];
    rt_field    = x.instr[20:16];
    rd_field    = x.instr[15:11];
    imm         = x.instr[15:0];
    instr_index = x.instr[25:0];
    pc          = x.pc;
    rs_data     = x.rs;
    rt_data     = x.rt;
    pc_advance  = x.adv;
    #2;
  endtask

  task automatic test_reset();
    stim_t s[$];
    exp_t got, want;
    s.push_back(mk_s(1, RS, {6'h03, 26'h10}, 32'h100, 0, 0, 1));
    exp_q.push_back(mk_e(0, 0, 0, 0, 0, 0, 0, 0, 32'h0));
    s.push_back(mk_s(0, OT, NOP, 32'h0, 0, 0, 0));
    exp_q.push_back(mk_e(0, 0, 0, 0, 0, 0, 0, 0, 32'h0));
    for (int i = 0; i < s.size(); i++) begin
      drive(s[i]);
      got = observe(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++; $display("[TB] FAIL reset step %0d: got %h want %h", i, got, want);
      end
    end
  endtask

  task automatic test_beq();
    stim_t s[$];
    exp_t got, want;
    s.push_back(mk_s(0, RS, {6'h04, 5'd1, 5'd2, 16'h0004}, 32'h100, 5, 5, 0));
    exp_q.push_back(mk_e(0, 0, 0, 0, 0, 0, 0, 0, 32'h0));
    s.push_back(mk_s(0, OT, NOP, 32'h104, 0, 0, 1));
    exp_q.push_back(mk_e(0, 0, 0, 0, 0, 1, 0, 0, 32'h114));
    s.push_back(mk_s(0, OT, NOP, 32'h104, 0, 0, 0));
    exp_q.push_back(mk_e(0, 0, 0, 0, 0, 1, 0, 0, 32'h114));
    s.push_back(mk_s(0, OT, NOP, 32'h104, 0, 0, 1));
    exp_q.push_back(mk_e(1, 0, 0, 0, 0, 1, 0, 0, 32'h114));
    s.push_back(mk_s(0, OT, NOP, 32'h114, 0, 0, 0));
    exp_q.push_back(mk_e(0, 0, 0, 0, 0, 0, 0, 0, 32'h114));
    for (int i = 0; i < s.size(); i++) begin
      drive(s[i]);
      got = observe(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++; $display("[TB] FAIL beq step %0d: got %h want %h", i, got, want);
      end
    end
  endtask

  // BGEZAL not taken still links; taken BLTZAL resolves together with its own advance.
  task automatic test_link();
    stim_t s[$];
    exp_t got, want;
    s.push_back(mk_s(0, RS, {6'h01, 5'd3, 5'h11, 16'h0010}, 32'h200, 32'hFFFF_FFFF, 0, 0));
    exp_q.push_back(mk_e(0, 0, 1, 0, 0, 0, 5'd31, 32'h208, 32'h114));
    s.push_back(mk_s(0, OT, NOP, 32'h204, 0, 0, 1));
    exp_q.push_back(mk_e(0, 0, 0, 0, 0, 0, 0, 0, 32'h114));
    s.push_back(mk_s(0, RS, {6'h01, 5'd3, 5'h10, 16'hFFFF}, 32'h300, 32'hFFFF_FFFF, 0, 1));
    exp_q.push_back(mk_e(0, 0, 1, 0, 0, 0, 5'd31, 32'h308, 32'h114));
    s.push_back(mk_s(0, OT, NOP, 32'h304, 0, 0, 1));
    exp_q.push_back(mk_e(1, 0, 0, 0, 0, 1, 0, 0, 32'h300));
    s.push_back(mk_s(0, OT, NOP, 32'h300, 0, 0, 0));
    exp_q.push_back(mk_e(0, 0, 0, 0, 0, 0, 0, 0, 32'h300));
    for (int i = 0; i < s.size(); i++) begin
      drive(s[i]);
      got = observe(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++; $display("[TB] FAIL link step %0d: got %h want %h", i, got, want);
      end
    end
  endtask

  task automatic test_likely();
    stim_t s[$];
    exp_t got, want, t;
    s.push_back(mk_s(0, RS, {6'h15, 5'd1, 5'd2, 16'h0008}, 32'h400, 7, 7, 0));
    t = mk_e(0, 1, 0, 0, 0, 0, 0, 0, 32'h300); t.nl = 6'b000000; exp_q.push_back(t);
    s.push_back(mk_s(0, OT, NOP, 32'h404, 0, 0, 1));
    exp_q.push_back(mk_e(0, 0, 0, 0, 0, 0, 0, 0, 32'h300));
    s.push_back(mk_s(0, RS, {6'h17, 5'd1, 5'd0, 16'h0002}, 32'h500, 5, 0, 0));
    exp_q.push_back(mk_e(0, 0, 0, 0, 0, 0, 0, 0, 32'h300));
    s.push_back(mk_s(0, OT, NOP, 32'h504, 0, 0, 1));
    t = mk_e(0, 0, 0, 0, 0, 1, 0, 0, 32'h50C); t.nl = 6'b000000; exp_q.push_back(t);
    s.push_back(mk_s(0, OT, NOP, 32'h504, 0, 0, 1));
    t = mk_e(1, 0, 0, 0, 0, 1, 0, 0, 32'h50C); t.nl = 6'b000000; exp_q.push_back(t);
    s.push_back(mk_s(0, OT, NOP, 32'h50C, 0, 0, 0));
    exp_q.push_back(mk_e(0, 0, 0, 0, 0, 0, 0, 0, 32'h50C));
    for (int i = 0; i < s.size(); i++) begin
      drive(s[i]);
      got = observe(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++; $display("[TB] FAIL likely step %0d: got %h want %h", i, got, want);
      end
    end
  endtask

  task automatic test_jreg();
    stim_t s[$];
    exp_t got, want;
    s.push_back(mk_s(0, RS, {6'h00, 5'd4, 5'd0, 5'd9, 5'd0, 6'h09}, 32'h600, 32'h2002, 0, 0));
    exp_q.push_back(mk_e(0, 0, 1, 1, 0, 0, 5'd9, 32'h608, 32'h50C));
    s.push_back(mk_s(0, OT, NOP, 32'h604, 0, 0, 1));
    exp_q.push_back(mk_e(0, 0, 0, 0, 0, 0, 0, 0, 32'h50C));
    s.push_back(mk_s(0, RS, {6'h00, 5'd4, 5'd0, 5'd0, 5'd0, 6'h08}, 32'h700, 32'h3000, 0, 0));
    exp_q.push_back(mk_e(0, 0, 0, 0, 0, 0, 0, 0, 32'h50C));
    s.push_back(mk_s(0, OT, NOP, 32'h704, 0, 0, 1));
    exp_q.push_back(mk_e(0, 0, 0, 0, 0, 1, 0, 0, 32'h3000));
    s.push_back(mk_s(0, OT, NOP, 32'h704, 0, 0, 1));
    exp_q.push_back(mk_e(1, 0, 0, 0, 0, 1, 0, 0, 32'h3000));
    for (int i = 0; i < s.size(); i++) begin
      drive(s[i]);
      got = observe(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++; $display("[TB] FAIL jreg step %0d: got %h want %h", i, got, want);
      end
    end
  endtask

  task automatic test_slot_violation();
    stim_t s[$];
    exp_t got, want;
    s.push_back(mk_s(0, RS, {6'h05, 5'd1, 5'd2, 16'h0010}, 32'h800, 1, 2, 0));
    exp_q.push_back(mk_e(0, 0, 0, 0, 0, 0, 0, 0, 32'h3000));
    s.push_back(mk_s(0, OT, NOP, 32'h804, 0, 0, 1));
    exp_q.push_back(mk_e(0, 0, 0, 0, 0, 1, 0, 0, 32'h844));
    s.push_back(mk_s(0, RS, {6'h03, 26'h123}, 32'h804, 0, 0, 0));
    exp_q.push_back(mk_e(0, 0, 0, 0, 1, 1, 0, 0, 32'h844));
    s.push_back(mk_s(0, OT, NOP, 32'h808, 0, 0, 1));
    exp_q.push_back(mk_e(1, 0, 0, 0, 0, 1, 0, 0, 32'h844));
    s.push_back(mk_s(0, OT, NOP, 32'h844, 0, 0, 0));
    exp_q.push_back(mk_e(0, 0, 0, 0, 0, 0, 0, 0, 32'h844));
    for (int i = 0; i < s.size(); i++) begin
      drive(s[i]);
      got = observe(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++; $display("[TB] FAIL slot step %0d: got %h want %h", i, got, want);
      end
    end
  endtask

  task automatic test_jump_reset();
    stim_t s[$];
    exp_t got, want;
    s.push_back(mk_s(0, RS, {6'h02, 26'h0000040}, 32'hF000_0000, 0, 0, 1));
    exp_q.push_back(mk_e(0, 0, 0, 0, 0, 0, 0, 0, 32'h844));
    s.push_back(mk_s(0, OT, NOP, 32'hF000_0004, 0, 0, 0));
    exp_q.push_back(mk_e(0, 0, 0, 0, 0, 1, 0, 0, 32'hF000_0100));
    s.push_back(mk_s(1, OT, NOP, 32'hF000_0004, 0, 0, 1));
    exp_q.push_back(mk_e(0, 0, 0, 0, 0, 0, 0, 0, 32'hF000_0100));
    s.push_back(mk_s(0, OT, NOP, 32'hF000_0008, 0, 0, 1));
    exp_q.push_back(mk_e(0, 0, 0, 0, 0, 0, 0, 0, 32'h0));
    for (int i = 0; i < s.size(); i++) begin
      drive(s[i]);
      got = observe(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++; $display("[TB] FAIL jump_reset step %0d: got %h want %h", i, got, want);
      end
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_beq();
    test_link();
    test_likely();
    test_jreg();
    test_slot_violation();
    test_jump_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
